prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//   Upstream stage of the AVR core: serial bootloader plus 256x16 program RAM. It
//   replaces the fixed program ROM. It receives a program frame over UART (8N1),
//   writes the words into RAM and then releases the core through core_run.
//   The core fetches opcodes through the registered read port.
// PARAMETERS
//   CLKS_PER_BIT  434    clk50 cycles per UART bit (50 MHz / 115200 baud); minimum 4
//   ADDR_W        8      program address width; must match the core ip width
//   SYNC_BYTE     8'hA5  byte that starts a frame
// PORTS
//   clk50         in   1       system clock; all logic on posedge
//   reset         in   1       synchronous, active-high reset
//   rxd           in   1       UART receive line; asynchronous, idles high
//   rd_addr       in   ADDR_W  fetch address (core ip)
//   rd_data       out  16      opcode at rd_addr; registered, 1-cycle latency
//   core_run      out  1       1 = program valid, core may execute; 0 = hold core in reset
//   load_ok       out  1       sticky: last frame loaded with a good checksum
//   load_err      out  1       sticky: last frame aborted (checksum or framing error)
// BEHAVIOUR
//   Reset: core_run=0, load_ok=0, load_err=0, rd_data=0, FSM=IDLE, RX=idle.
//     RAM contents are not cleared.
//   RX synchroniser: rxd passes through 2 flops before any use.
//   RX byte engine:
//     - A falling edge starts a byte. Sample at CLKS_PER_BIT/2; if the line is
//       high again, discard it as a glitch.
//     - Sample 8 data bits LSB-first, each one CLKS_PER_BIT after the previous.
//     - Sample the stop bit. 1 = pulse byte_valid for 1 cycle.
//       0 = pulse frame_err for 1 cycle; the byte is dropped.
//   Frame format: SYNC, N, then 2*N' data bytes, then CHK.
//     - N' = N, except N=0 means 256 words.
//     - Data bytes come in pairs, low byte first, written to address 0, 1, 2, ...
//     - CHK = 8-bit sum (mod 256) of all data bytes; N and SYNC are excluded.
//   Loader FSM (advances on byte_valid only):
//     - IDLE: a SYNC byte goes to CNT, clears load_ok/load_err and sets core_run=0.
//       Any other byte is ignored.
//     - CNT: latch N; clear addr and sum; go to LO.
//     - LO: latch the low byte; add to sum; go to HI.
//     - HI: write {byte,lo} to RAM[addr] in the same cycle; add to sum;
//       addr++ (ADDR_W wrap).
//       If it is the last word, go to CHK; otherwise go to LO.
//     - CHK: if sum==byte, set load_ok=1 and core_run=1 and go to RUN.
//       Otherwise set load_err=1 and go to IDLE with core_run=0.
//     - RUN: core_run stays 1. A SYNC byte starts a reload (as in IDLE: core_run=0,
//       go to CNT). Other bytes are ignored.
//   frame_err in CNT/LO/HI/CHK: set load_err=1, go to IDLE, core_run=0.
//     frame_err in IDLE or RUN is ignored.
//   Already-written words stay in RAM after an abort; core_run=0 protects the core.
//   Read port: rd_data <= RAM[rd_addr] on every clk50 edge, in every state.
//     On a write to the same address in the same cycle, rd_data returns the old word.
//   Reset mid-frame: FSM goes to IDLE and all outputs return to their reset values
//     on the next edge. A partial byte on the line is discarded, and RX re-arms on
//     the next falling edge after rxd has been high.
// TESTING  (CLKS_PER_BIT=8)
//   1. Reset asserted -> core_run=0, load_ok=0, load_err=0, rd_data=0000;
//      a held rxd=1 produces no bytes.
//   2. Send A5 02 0F E0 14 E0 E3 -> core_run=1, load_ok=1.
//      rd_addr=0 gives rd_data=E00F; rd_addr=1 gives E014 one cycle later.
//   3. Send A5 01 34 12 00 (bad CHK) -> load_err=1, core_run=0, RAM[0]=1234;
//      a following valid frame gives load_ok=1, load_err=0.
//   4. Stop bit=0 on the 3rd byte of a frame -> load_err=1, FSM IDLE.
//      A 3-cycle low glitch on idle rxd -> no byte, no state change.
//   5. N=00 with 512 bytes of value 01 and CHK=00 -> load_ok=1; RAM[255]=0101;
//      addr wraps to 0.
//      Reset asserted after 100 bytes -> all outputs at reset values.
//   6. In RUN, send A5 -> core_run drops to 0 in the cycle after the stop bit;
//      the reload completes and core_run returns to 1.

Source files
------------

// File: rtl/prog_loader.sv
// UART bootloader for the AVR core: receives a checksummed program frame into a
// 256x16 program RAM, then releases the core through core_run.
//   state  | meaning
//   L_IDLE | wait for SYNC, core held
//   L_CNT  | next byte is word count N (0 = 256)
//   L_LO   | next byte is low half of a word
//   L_HI   | next byte is high half; word written
//   L_CHK  | next byte is the checksum
//   L_RUN  | program valid, core running; SYNC reloads
module prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              rxd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic              core_run,
    output logic              load_ok,
    output logic              load_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CNT, L_LO, L_HI, L_CHK, L_RUN} ld_state_t;

    rx_state_t        rx_state, rx_state_n;
    logic             rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0] bit_tmr, bit_tmr_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_valid, frame_err;

    ld_state_t        ld_state, ld_state_n;
    logic [8:0]       words_left, words_left_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [7:0]       sum, sum_n, lo_byte, lo_byte_n;
    logic             core_run_n, load_ok_n, load_err_n;
    logic             we;
    logic [15:0]      wr_word;

    logic [15:0] mem [1 << ADDR_W];

    // Sync flops reset low so a line already low at reset cannot look like a start edge.
    always_ff @(posedge clk50) begin
        if (reset) begin
            rx_s1    <= 1'b0;
            rx_s2    <= 1'b0;
            rx_prev  <= 1'b0;
            rx_state <= RX_IDLE;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            bit_tmr  <= bit_tmr_n;
            bit_idx  <= bit_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        bit_tmr_n  = bit_tmr;
        bit_idx_n  = bit_idx;
        rx_shift_n = rx_shift;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (rx_state != RX_IDLE && bit_tmr != '0)
            bit_tmr_n = bit_tmr - 1'b1;
        case (rx_state)
            RX_IDLE: if (rx_prev && !rx_s2) begin
                rx_state_n = RX_START;
                bit_tmr_n  = HALF_LD;
            end
            RX_START: if (bit_tmr == '0) begin
                if (rx_s2) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_DATA;
                    bit_tmr_n  = FULL_LD;
                    bit_idx_n  = '0;
                end
            end
            RX_DATA: if (bit_tmr == '0) begin
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                bit_tmr_n  = FULL_LD;
                bit_idx_n  = bit_idx + 3'd1;
                if (bit_idx == 3'd7)
                    rx_state_n = RX_STOP;
            end
            RX_STOP: if (bit_tmr == '0) begin
                byte_valid = rx_s2;
                frame_err  = !rx_s2;
                rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            ld_state   <= L_IDLE;
            words_left <= '0;
            wr_addr    <= '0;
            sum        <= '0;
            lo_byte    <= '0;
            core_run   <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            ld_state   <= ld_state_n;
            words_left <= words_left_n;
            wr_addr    <= wr_addr_n;
            sum        <= sum_n;
            lo_byte    <= lo_byte_n;
            core_run   <= core_run_n;
            load_ok    <= load_ok_n;
            load_err   <= load_err_n;
        end
    end

    always_comb begin
        ld_state_n   = ld_state;
        words_left_n = words_left;
        wr_addr_n    = wr_addr;
        sum_n        = sum;
        lo_byte_n    = lo_byte;
        core_run_n   = core_run;
        load_ok_n    = load_ok;
        load_err_n   = load_err;
        we           = 1'b0;
        wr_word      = {rx_shift, lo_byte};
        if (frame_err) begin
            if (ld_state != L_IDLE && ld_state != L_RUN) begin
                load_err_n = 1'b1;
                core_run_n = 1'b0;
                ld_state_n = L_IDLE;
            end
        end else if (byte_valid) begin
            case (ld_state)
                L_IDLE, L_RUN: if (rx_shift == SYNC_BYTE) begin
                    ld_state_n = L_CNT;
                    load_ok_n  = 1'b0;
                    load_err_n = 1'b0;
                    core_run_n = 1'b0;
                end
                L_CNT: begin
                    words_left_n = (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
                    wr_addr_n    = '0;
                    sum_n        = '0;
                    ld_state_n   = L_LO;
                end
                L_LO: begin
                    lo_byte_n  = rx_shift;
                    sum_n      = sum + rx_shift;
                    ld_state_n = L_HI;
                end
                L_HI: begin
                    we           = 1'b1;
                    sum_n        = sum + rx_shift;
                    wr_addr_n    = wr_addr + 1'b1;
                    words_left_n = words_left - 9'd1;
                    ld_state_n   = (words_left == 9'd1) ? L_CHK : L_LO;
                end
                L_CHK: begin
                    if (sum == rx_shift) begin
                        load_ok_n  = 1'b1;
                        core_run_n = 1'b1;
                        ld_state_n = L_RUN;
                    end else begin
                        load_err_n = 1'b1;
                        core_run_n = 1'b0;
                        ld_state_n = L_IDLE;
                    end
                end
                default: ld_state_n = L_IDLE;
            endcase
        end
    end

    // Read and write share the edge, so a same-address read returns the old word.
    always_ff @(posedge clk50) begin
        if (we && !reset)
            mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk50) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end
endmodule
